// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: 4-digit 7-segment scan controller sharing the display between the score and flash messages.
// Source switches happen only on frame boundaries, so a frame never mixes score and message.
module seg_scan_arbiter #(
  parameter int REFRESH_DIV  = 100000,
  parameter int FLASH_FRAMES = 250
) (
  input  logic        Clk100M,
  input  logic        Rst_n,
  input  logic [15:0] score_val,
  input  logic [3:0]  score_dp,
  input  logic        blank,
  input  logic        msg_req,
  input  logic [31:0] msg_val,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic        tick,
  output logic [7:0]  seg,
  output logic [3:0]  an
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = $clog2(FLASH_FRAMES + 1);
  typedef enum logic [1:0] {SCORE, PEND, MSG} state_t;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  state_t        r_state;
  logic [HW-1:0] r_hold;
  logic [31:0]   r_msg;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_ack;
  logic          r_busy;
  logic          w_tick;
  logic          w_frame;
  logic [3:0]    w_nib;
  logic [6:0]    w_hex;
  logic [7:0]    w_seg;
  assign w_tick   = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_frame  = w_tick && (r_idx == 2'd3);
  assign w_nib    = score_val[{r_idx, 2'b00} +: 4];
  assign w_seg    = (r_state == MSG) ? r_msg[{r_idx, 3'b000} +: 8] : {~score_dp[r_idx], w_hex};
  assign tick     = w_tick;
  assign seg      = r_seg;
  assign an       = r_an;
  assign msg_ack  = r_ack;
  assign msg_busy = r_busy;
  always_comb begin
    w_hex = 7'h7F;
    case (w_nib)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      default: w_hex = 7'h0E;
    endcase
  end
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      r_seg <= 8'hFF;
      r_an  <= 4'hF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;
      r_seg <= w_seg;
      r_an  <= blank ? 4'hF : ~(4'b0001 << r_idx);
    end
  end
  // hold counts remaining message frames; leaving MSG and dropping busy share one edge
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= SCORE;
      r_hold  <= '0;
      r_msg   <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        SCORE: if (msg_req) begin
          r_msg   <= msg_val;
          r_ack   <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= PEND;
        end
        PEND: if (w_frame) begin
          r_hold  <= HW'(FLASH_FRAMES);
          r_state <= MSG;
        end
        MSG: if (w_frame) begin
          r_hold <= r_hold - HW'(1);
          if (r_hold == HW'(1)) begin
            r_state <= SCORE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= SCORE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: directed and random stimulus against a frame-arithmetic reference model.
module tb_seg_scan_arbiter;
  localparam int RD = 4;
  localparam int FF = 2;
  localparam int FL = 4 * RD;
  logic        clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic [15:0] score_val = '0;
  logic [3:0]  score_dp = '0;
  logic        blank = 1'b0;
  logic        msg_req = 1'b0;
  logic [31:0] msg_val = '0;
  logic        msg_ack, msg_busy, tick;
  logic [7:0]  seg;
  logic [3:0]  an;
  int checks = 0, errors = 0;
  int n = 0, m_start = 0, m_end = 0, reqs_left = 0;
  bit m_busy = 0;
  logic [31:0] m_msg = '0;
  logic [6:0] hex_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg_scan_arbiter #(.REFRESH_DIV(RD), .FLASH_FRAMES(FF)) dut (
    .Clk100M(clk), .Rst_n(Rst_n), .score_val(score_val), .score_dp(score_dp), .blank(blank),
    .msg_req(msg_req), .msg_val(msg_val), .msg_ack(msg_ack), .msg_busy(msg_busy), .tick(tick),
    .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask
  // Message occupies the frames strictly after the first frame end following acceptance.
  task automatic step();
    int pre, idx, r;
    bit src, e_ack;
    logic [7:0] e_seg;
    logic [3:0] e_an;
    @(posedge clk);
    pre = n;
    idx = (pre / RD) % 4;
    src = m_busy && pre > m_start;
    e_seg = src ? m_msg[idx*8 +: 8] : {~score_dp[idx], hex_t[score_val[idx*4 +: 4]]};
    e_an = blank ? 4'hF : ~(4'b0001 << idx);
    e_ack = 0;
    if (!m_busy && msg_req) begin
      m_msg = msg_val;
      m_busy = 1;
      e_ack = 1;
      r = pre % FL;
      m_start = pre + FL - (r + 1) % FL;
      m_end = m_start + FL * FF;
    end else if (m_busy && pre == m_end) m_busy = 0;
    n = pre + 1;
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("ack", 32'(msg_ack), 32'(e_ack));
    chk("busy", 32'(msg_busy), 32'(m_busy));
    chk("tick", 32'(tick), 32'(n % RD == RD - 1));
    if (e_ack) begin
      reqs_left--;
      if (reqs_left > 0) msg_val = $urandom;
      else msg_req = 0;
    end
  endtask
  task automatic do_reset(input int cycles);
    msg_req = 0;
    reqs_left = 0;
    Rst_n = 0;
    #1;
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_busy", 32'(msg_busy), 32'h0);
    chk("rst_ack", 32'(msg_ack), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_hold_seg", 32'(seg), 32'hFF);
    Rst_n = 1;
    n = 0;
    m_busy = 0;
  endtask
  initial begin
    #2;
    score_val = 16'h1208;
    do_reset(2);
    repeat (6) step();
    do_reset(1);
    repeat (32) step();
    while ((n / RD) % 4 != 1) step();
    msg_val = 32'h8E8E8E8E;
    msg_req = 1;
    reqs_left = 2;
    repeat (4 * FL * FF + 3 * FL) step();
    blank = 1;
    repeat (10) step();
    blank = 0;
    repeat (12) step();
    while (n % FL != FL - 1) step();
    msg_val = $urandom;
    msg_req = 1;
    reqs_left = 1;
    repeat (FL * FF + 2 * FL) step();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) score_val = 16'($urandom);
      if ($urandom_range(0, 7) == 0) score_dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      if (!msg_req && $urandom_range(0, 29) == 0) begin
        msg_val = $urandom;
        msg_req = 1;
        reqs_left = $urandom_range(1, 2);
      end
      step();
    end
    blank = 0;
    msg_val = $urandom;
    msg_req = 1;
    reqs_left = 1;
    for (int i = 0; i < 100 && !(m_busy && n > m_start + 5); i++) step();
    chk("msg_on_screen", 32'(m_busy && n > m_start + 5), 32'h1);
    do_reset(2);
    repeat (3 * FL) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
